// File: rtl/axi4_master_bridge.sv
// Simple request/response to AXI4 master bridge.
// Carries one transaction at a time: reads as INCR bursts, writes as single beats.
module axi4_master_bridge #(
  parameter logic [3:0] AXI_ID  = 4'h0,
  parameter logic [7:0] MAX_LEN = 8'd15
) (
  input  logic        clock,
  input  logic        reset,
  // Request side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_len,
  // Response side
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_last,
  output logic        rsp_err,
  // AXI write address
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  // AXI write data
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  // AXI write response
  input  logic        bvalid,
  output logic        bready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  // AXI read address
  output logic        arvalid,
  input  logic        arready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  // AXI read data
  input  logic        rvalid,
  output logic        rready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast
);

  typedef enum logic [2:0] {StIdle, StAr, StR, StAww, StB} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  size_q;
  logic [7:0]  len_q;
  logic [7:0]  beat_q, beat_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [7:0]  len_clamped;
  logic        len_hit;
  logic        final_beat;

  // IDs are not checked: only one transaction is ever outstanding.
  logic unused_id;
  assign unused_id = ^{rid, bid};

  assign len_clamped = (req_len > MAX_LEN) ? MAX_LEN : req_len;
  assign len_hit     = (beat_q == len_q);
  assign final_beat  = rlast | len_hit;

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arburst = 2'b01;
  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = size_q;
  assign awburst = 2'b01;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;

  // State, beat counter, handshake flags and latched request fields.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      size_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (req_valid && req_ready) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        size_q  <= req_size;
        len_q   <= len_clamped;
      end
    end
  end

  // Next-state and handshake outputs; reset overrides every valid/ready.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    req_ready = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_last  = 1'b0;
    rsp_err   = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (req_valid) state_d = req_write ? StAww : StAr;
      end
      StAr: begin
        arvalid = 1'b1;
        if (arready) begin
          state_d = StR;
          beat_d  = '0;
        end
      end
      StR: begin
        rready    = rsp_ready;
        rsp_valid = rvalid;
        rsp_rdata = rdata;
        rsp_last  = final_beat;
        // Slave's rlast and our own count must agree on the final beat.
        rsp_err   = (rresp != 2'b00) | (rlast != len_hit);
        if (rvalid && rsp_ready) begin
          beat_d = beat_q + 8'd1;
          if (final_beat) state_d = StIdle;
        end
      end
      StAww: begin
        awvalid   = ~aw_done_q;
        wvalid    = ~w_done_q;
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = StB;
      end
      StB: begin
        bready    = rsp_ready;
        rsp_valid = bvalid;
        rsp_last  = 1'b1;
        rsp_err   = (bresp != 2'b00);
        if (bvalid && rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (reset) begin
      req_ready = 1'b0;
      arvalid   = 1'b0;
      rready    = 1'b0;
      awvalid   = 1'b0;
      wvalid    = 1'b0;
      bready    = 1'b0;
      rsp_valid = 1'b0;
    end
  end

endmodule

// File: doc/axi4_master_bridge.md
AXI4_MASTER_BRIDGE -- requirements
Module: axi4_master_bridge

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'h0, value driven on awid and arid.
REQ-002 SHALL have parameter MAX_LEN, default 8'd15, largest accepted req_len; larger values are clamped to MAX_LEN.
REQ-003 SHALL have port clock  in  1  clock; all logic on the rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1: request handshake.
REQ-006 SHALL have ports req_write in 1, req_addr in 32, req_wdata in 32, req_wstrb in 4, req_size in 3, req_len in 8 (read beats minus 1).
REQ-007 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out 32, rsp_last out 1, rsp_err out 1.
REQ-008 SHALL have AXI4 master ports aw{valid,ready,id[4],addr[32],len[8],size[3],burst[2]}, w{valid,ready,data[32],strb[4],last}, b{valid,ready,id[4],resp[2]}.
REQ-009 SHALL have AXI4 master ports ar{valid,ready,id[4],addr[32],len[8],size[3],burst[2]}, r{valid,ready,id[4],data[32],resp[2],last}.

Function
REQ-010 SHALL implement FSM states IDLE, AR, R, AWW, B; one transaction outstanding at a time.
REQ-011 SHALL drive req_ready=1 only in IDLE; on req_valid&req_ready, latch all req_* fields.
REQ-012 SHALL go IDLE->AR on an accepted read, IDLE->AWW on an accepted write.
REQ-013 SHALL assert arvalid in AR from the cycle after acceptance; araddr/arlen/arsize from latched fields; arburst=2'b01 (INCR); hold stable until arready.
REQ-014 SHALL go AR->R on arvalid&arready and clear the beat counter to 0.
REQ-015 In R, SHALL drive rready=rsp_ready, rsp_valid=rvalid, rsp_rdata=rdata combinationally.
REQ-016 SHALL increment the beat counter on each rvalid&rready.
REQ-017 SHALL end a read on the handshaken beat where rlast=1 or counter==latched len, whichever comes first.
REQ-018 SHALL drive rsp_last=1 on that final beat and return to IDLE the following cycle.
REQ-019 SHALL set rsp_err on a read beat when rresp!=0, when rlast=1 with counter!=len, or when counter==len with rlast=0.
REQ-020 In AWW, SHALL assert awvalid and wvalid together, with awlen=0, awburst=2'b01, wlast=1, wdata/wstrb latched.
REQ-021 In AWW, SHALL deassert awvalid and wvalid independently after their own handshake; aw and w handshakes in the same cycle or in either order are legal.
REQ-022 SHALL go AWW->B once both aw and w handshakes have completed; this includes the same cycle.
REQ-023 In B, SHALL drive bready=rsp_ready, rsp_valid=bvalid, rsp_last=1, rsp_rdata=0, rsp_err=(bresp!=0).
REQ-024 SHALL go B->IDLE on bvalid&bready.
REQ-025 SHALL drive rready=0 and bready=0 outside R and B; rsp_valid SHALL be 0 in IDLE, AR and AWW.
REQ-026 SHALL ignore rid/bid values; a response arriving in a non-matching state SHALL NOT be acknowledged.
REQ-027 SHALL give minimum latency, accept-to-first-rsp_valid, of 2 cycles when the slave responds with ready and valid at the earliest legal cycle.

Reset
REQ-028 While reset=1, SHALL force state IDLE, and awvalid, wvalid, arvalid, rready, bready, rsp_valid all 0.
REQ-029 While reset=1, SHALL hold req_ready=0, then req_ready=1 from the first cycle after reset deasserts.
REQ-030 On reset asserted mid-transaction, SHALL abandon the transaction with no rsp issued; the counter and latched fields reset to 0.

Verification
REQ-031 Read, addr 0x80000000, len 0, slave arready=1 and data 0x12345678 rlast=1 -> arlen=0, arburst=01; one rsp with rdata 0x12345678, last=1, err=0.
REQ-032 Read burst, len 3 at 0x80000100, rsp_ready toggled 1/0 -> 4 rsp beats in order, rready tracks rsp_ready, last only on beat 4.
REQ-033 Write 0xa00003f8, wdata 0x41, wstrb 0001; wready one cycle before awready -> wvalid drops first, then awvalid; one rsp with last=1, err=0 after bvalid.
REQ-034 Read len 3 where the slave sends rlast on beat 2 -> transfer ends after beat 2, rsp_err=1 on that beat, FSM back in IDLE.
REQ-035 Write with bresp=2'b10 -> rsp_err=1; read with rresp=2'b10 on beat 0 -> rsp_err=1 on that beat only.
REQ-036 Reset asserted in R after 1 of 4 beats -> next cycle all valids and readys 0; new read after reset completes normally.
